// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the four-stage pipeline stall controller.
package pipeline_ctrl_pkg;

    localparam int MICROCODE_W = 22;
    localparam int INST_DATA_W = 25;

    // Bubbles carry all-zero microcode: no register write, no source reads.
    localparam logic [MICROCODE_W-1:0] NOP_MICROCODE        = '0;
    localparam logic [INST_DATA_W-1:0] NOP_INSTRUCTION_DATA = '0;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_t;

    // Per-stage register update selection.
    typedef enum logic [1:0] {
        SEL_LOAD   = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_BUBBLE = 2'd2
    } stage_sel_t;

    typedef struct packed {
        logic                   valid;
        logic [MICROCODE_W-1:0] microcode;
        logic [INST_DATA_W-1:0] instruction_data;
    } stage_t;

    localparam stage_t NOP_STAGE = '{
        valid:            1'b0,
        microcode:        NOP_MICROCODE,
        instruction_data: NOP_INSTRUCTION_DATA
    };

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Fetch handshake between the fetch unit (master) and stage s0 (slave).
interface pipeline_stall_controller_if;
    import pipeline_ctrl_pkg::*;

    logic                   fetch_valid;
    logic [MICROCODE_W-1:0] fetch_microcode;
    logic [INST_DATA_W-1:0] fetch_instruction_data;
    logic                   fetch_ready;

    modport master (
        output fetch_valid,
        output fetch_microcode,
        output fetch_instruction_data,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_microcode,
        input  fetch_instruction_data,
        output fetch_ready
    );

endinterface

// File: rtl/pipeline_stall_controller_stage_reg.sv
// One pipeline stage register: load a new value, hold, or take a bubble.
module pipeline_stage_reg
    import pipeline_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  stage_sel_t sel,
    input  stage_t     d,
    output stage_t     q
);

    // Stage contents update on each edge according to sel; reset empties the stage.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every stage samples its neighbour's pre-edge value.
        if (rst) begin
            q <= NOP_STAGE;
        end else begin
            unique case (sel)
                SEL_LOAD:   q <= d;
                SEL_HOLD:   q <= q;
                SEL_BUBBLE: q <= NOP_STAGE;
                default:    q <= NOP_STAGE;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Four-stage pipeline register owner: advance, dependency stall, branch flush
// and a saturating count of held cycles.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 3,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    pipeline_stall_controller_if.slave    fetch,
    input  logic                          data_dependency,
    input  logic                          flush,
    output logic [MICROCODE_W-1:0]        microcode_s0,
    output logic [MICROCODE_W-1:0]        microcode_s1,
    output logic [MICROCODE_W-1:0]        microcode_s2,
    output logic [MICROCODE_W-1:0]        microcode_s3,
    output logic [INST_DATA_W-1:0]        instruction_data_s0,
    output logic [INST_DATA_W-1:0]        instruction_data_s1,
    output logic [INST_DATA_W-1:0]        instruction_data_s2,
    output logic [INST_DATA_W-1:0]        instruction_data_s3,
    output logic                          valid_s0,
    output logic                          valid_s1,
    output logic                          valid_s2,
    output logic                          valid_s3,
    output logic                          currently_blocked,
    output logic [STALL_CNT_W-1:0]        stall_cycles
);

    localparam int                     CNT_W    = 4;
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]       CNT_INIT = CNT_W'(STALL_CYCLES - 1);
    localparam logic [STALL_CNT_W-1:0] SC_ONE   = STALL_CNT_W'(1);

    stall_state_t           state_q, state_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cycles_q;
    logic                   count_hold;
    logic                   dep;
    logic                   hold;

    stage_t     stage_q [4];
    stage_t     stage_d [4];
    stage_sel_t sel     [4];
    stage_t     fetch_stage;

    // A dependency only matters when s0 carries a real instruction.
    assign dep  = data_dependency & stage_q[0].valid;
    assign hold = ~flush & ((state_q == STALL) | ((state_q == RUN) & dep));

    assign fetch.fetch_ready = ~rst & ~flush & (state_q == RUN) & ~dep;

    // Stage data paths and per-stage load/hold/bubble selection.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        fetch_stage = NOP_STAGE;
        if (fetch.fetch_valid) begin
            fetch_stage.valid            = 1'b1;
            fetch_stage.microcode        = fetch.fetch_microcode;
            fetch_stage.instruction_data = fetch.fetch_instruction_data;
        end
        stage_d[0] = fetch_stage;
        stage_d[1] = stage_q[0];
        stage_d[2] = stage_q[1];
        stage_d[3] = stage_q[2];
        sel[0]     = SEL_LOAD;
        sel[1]     = SEL_LOAD;
        sel[2]     = SEL_LOAD;
        sel[3]     = SEL_LOAD;
        if (flush) begin
            sel[0] = SEL_BUBBLE;
            sel[1] = SEL_BUBBLE;
        end else if (hold) begin
            sel[0] = SEL_HOLD;
            sel[1] = SEL_BUBBLE;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_stage
        pipeline_stage_reg u_stage (
            .clk (clk),
            .rst (rst),
            .sel (sel[i]),
            .d   (stage_d[i]),
            .q   (stage_q[i])
        );
    end

    // Stall FSM next state: flush overrides both a new dependency and an ongoing stall.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        count_hold  = 1'b0;
        if (flush) begin
            state_d     = RUN;
            stall_cnt_d = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (dep) begin
                        state_d     = STALL;
                        stall_cnt_d = CNT_INIT;
                        count_hold  = 1'b1;
                    end
                end
                STALL: begin
                    count_hold = 1'b1;
                    if (stall_cnt_q == CNT_ONE) begin
                        state_d = RUN;
                    end else begin
                        stall_cnt_d = stall_cnt_q - CNT_ONE;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // FSM state, stall countdown and saturating held-cycle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            stall_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            if (count_hold && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + SC_ONE;
            end
        end
    end

    assign currently_blocked = (state_q == STALL);
    assign stall_cycles      = stall_cycles_q;

    assign microcode_s0        = stage_q[0].microcode;
    assign microcode_s1        = stage_q[1].microcode;
    assign microcode_s2        = stage_q[2].microcode;
    assign microcode_s3        = stage_q[3].microcode;
    assign instruction_data_s0 = stage_q[0].instruction_data;
    assign instruction_data_s1 = stage_q[1].instruction_data;
    assign instruction_data_s2 = stage_q[2].instruction_data;
    assign instruction_data_s3 = stage_q[3].instruction_data;
    assign valid_s0            = stage_q[0].valid;
    assign valid_s1            = stage_q[1].valid;
    assign valid_s2            = stage_q[2].valid;
    assign valid_s3            = stage_q[3].valid;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: directed table, hand-written
// corner sequences and randomized stimulus against a queue-style reference model.
module tb_pipeline_stall_controller;
    import pipeline_ctrl_pkg::*;

    localparam int STALL_CYCLES = 3;

    logic clk = 1'b0;
    logic rst;
    logic data_dependency;
    logic flush;

    always #5 clk = ~clk;

    pipeline_stall_controller_if fif  ();
    pipeline_stall_controller_if fif2 ();

    assign fif2.fetch_valid            = fif.fetch_valid;
    assign fif2.fetch_microcode        = fif.fetch_microcode;
    assign fif2.fetch_instruction_data = fif.fetch_instruction_data;

    logic [MICROCODE_W-1:0] mc  [4];
    logic [INST_DATA_W-1:0] id  [4];
    logic                   vs  [4];
    logic                   blk;
    logic [15:0]            sc;

    logic [MICROCODE_W-1:0] mc2 [4];
    logic [INST_DATA_W-1:0] id2 [4];
    logic                   vs2 [4];
    logic                   blk2;
    logic [3:0]             sc2;

    pipeline_stall_controller #(.STALL_CYCLES(STALL_CYCLES), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fetch(fif.slave),
        .data_dependency(data_dependency), .flush(flush),
        .microcode_s0(mc[0]), .microcode_s1(mc[1]), .microcode_s2(mc[2]), .microcode_s3(mc[3]),
        .instruction_data_s0(id[0]), .instruction_data_s1(id[1]),
        .instruction_data_s2(id[2]), .instruction_data_s3(id[3]),
        .valid_s0(vs[0]), .valid_s1(vs[1]), .valid_s2(vs[2]), .valid_s3(vs[3]),
        .currently_blocked(blk), .stall_cycles(sc)
    );

    pipeline_stall_controller #(.STALL_CYCLES(STALL_CYCLES), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .fetch(fif2.slave),
        .data_dependency(data_dependency), .flush(flush),
        .microcode_s0(mc2[0]), .microcode_s1(mc2[1]), .microcode_s2(mc2[2]), .microcode_s3(mc2[3]),
        .instruction_data_s0(id2[0]), .instruction_data_s1(id2[1]),
        .instruction_data_s2(id2[2]), .instruction_data_s3(id2[3]),
        .valid_s0(vs2[0]), .valid_s1(vs2[1]), .valid_s2(vs2[2]), .valid_s3(vs2[3]),
        .currently_blocked(blk2), .stall_cycles(sc2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: four slots, a count of cycles s0 remains held, total held cycles.
    stage_t m_stage [4];
    int     m_hold_left;
    int     m_held_total;
    logic   fr_sample;
    logic   fr2_sample;

    function automatic stage_t make_stage(input logic v, input int tag);
        stage_t s;
        s.valid            = v;
        s.microcode        = MICROCODE_W'(32'h100 + tag);
        s.instruction_data = INST_DATA_W'(32'h1000 + tag);
        return s;
    endfunction

    task automatic model_step(input logic r, input logic fv, input stage_t f,
                              input logic dd, input logic fl);
        if (r) begin
            for (int i = 0; i < 4; i++) m_stage[i] = NOP_STAGE;
            m_hold_left  = 0;
            m_held_total = 0;
        end else if (fl) begin
            m_stage[3]  = m_stage[2];
            m_stage[2]  = m_stage[1];
            m_stage[1]  = NOP_STAGE;
            m_stage[0]  = NOP_STAGE;
            m_hold_left = 0;
        end else begin
            if (m_hold_left == 0 && dd && m_stage[0].valid) m_hold_left = STALL_CYCLES;
            m_stage[3] = m_stage[2];
            m_stage[2] = m_stage[1];
            if (m_hold_left > 0) begin
                m_stage[1] = NOP_STAGE;
                m_hold_left--;
                m_held_total++;
            end else begin
                m_stage[1] = m_stage[0];
                m_stage[0] = fv ? f : NOP_STAGE;
            end
        end
    endtask

    // One clock: drive inputs, check combinational fetch_ready, clock, compare everything.
    task automatic step(input logic r, input logic fv, input logic [MICROCODE_W-1:0] fmc,
                        input logic [INST_DATA_W-1:0] fid, input logic dd, input logic fl);
        stage_t f;
        logic   exp_fr;
        int     exp16;
        int     exp4;
        rst                        = r;
        fif.fetch_valid            = fv;
        fif.fetch_microcode        = fmc;
        fif.fetch_instruction_data = fid;
        data_dependency            = dd;
        flush                      = fl;
        #1;
        exp_fr     = !r && !fl && (m_hold_left == 0) && !(dd && m_stage[0].valid);
        fr_sample  = fif.fetch_ready;
        fr2_sample = fif2.fetch_ready;
        check("fetch_ready", 64'(fr_sample), 64'(exp_fr));
        check("sat_fetch_ready", 64'(fr2_sample), 64'(exp_fr));
        f.valid            = 1'b1;
        f.microcode        = fmc;
        f.instruction_data = fid;
        model_step(r, fv, f, dd, fl);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s%0d_valid", i), 64'(vs[i]), 64'(m_stage[i].valid));
            check($sformatf("s%0d_microcode", i), 64'(mc[i]), 64'(m_stage[i].microcode));
            check($sformatf("s%0d_inst_data", i), 64'(id[i]), 64'(m_stage[i].instruction_data));
        end
        exp16 = (m_held_total > 65535) ? 65535 : m_held_total;
        exp4  = (m_held_total > 15) ? 15 : m_held_total;
        check("currently_blocked", 64'(blk), 64'(m_hold_left > 0));
        check("stall_cycles", 64'(sc), 64'(exp16));
        check("sat_stall_cycles", 64'(sc2), 64'(exp4));
        check("sat_blocked", 64'(blk2), 64'(m_hold_left > 0));
    endtask

    task automatic step_tag(input logic r, input logic fv, input int tag,
                            input logic dd, input logic fl);
        stage_t s;
        s = make_stage(1'b1, tag);
        step(r, fv, s.microcode, s.instruction_data, dd, fl);
    endtask

    typedef struct {
        logic       rst;
        logic       fv;
        logic       dd;
        logic       fl;
        int         tag;
        logic [3:0] exp_valid;   // {s3, s2, s1, s0}
        logic       exp_fr;
        logic       exp_blk;
        int         exp_sc;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic fv, input logic dd, input logic fl,
                                input int tag, input logic [3:0] ev, input logic efr,
                                input logic eblk, input int esc);
        vec_t v;
        v.rst = r; v.fv = fv; v.dd = dd; v.fl = fl; v.tag = tag;
        v.exp_valid = ev; v.exp_fr = efr; v.exp_blk = eblk; v.exp_sc = esc;
        return v;
    endfunction

    vec_t tbl [16];

    initial begin
        for (int i = 0; i < 4; i++) m_stage[i] = NOP_STAGE;
        m_hold_left  = 0;
        m_held_total = 0;

        //          rst  fv   dd   fl   tag  valid  fr   blk  sc
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 4'b0000, 1'b0, 1'b0, 0); // reset
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1, 4'b0001, 1'b1, 1'b0, 0); // stream I1..I4
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 2, 4'b0011, 1'b1, 1'b0, 0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 3, 4'b0111, 1'b1, 1'b0, 0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4, 4'b1111, 1'b1, 1'b0, 0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 5, 4'b1101, 1'b0, 1'b1, 1); // I4 depends on I3
        tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5, 4'b1001, 1'b0, 1'b1, 2);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5, 4'b0001, 1'b0, 1'b0, 3);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 5, 4'b0011, 1'b1, 1'b0, 3); // I4 reaches s1
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 4'b0110, 1'b1, 1'b0, 3); // empty s0
        tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 6, 4'b1101, 1'b1, 1'b0, 3); // dep ignored, s0 empty
        tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b0, 7, 4'b1001, 1'b0, 1'b1, 4); // stall on I6
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 7, 4'b0000, 1'b0, 1'b0, 4); // flush mid-stall
        tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, 7, 4'b0001, 1'b1, 1'b0, 4);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b1, 8, 4'b0000, 1'b0, 1'b0, 4); // flush beats dep
        tbl[15] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8, 4'b0001, 1'b1, 1'b0, 4);

        for (int i = 0; i < 16; i++) begin
            step_tag(tbl[i].rst, tbl[i].fv, tbl[i].tag, tbl[i].dd, tbl[i].fl);
            check($sformatf("tbl%0d_fetch_ready", i), 64'(fr_sample), 64'(tbl[i].exp_fr));
            check($sformatf("tbl%0d_valids", i), 64'({vs[3], vs[2], vs[1], vs[0]}),
                  64'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_blocked", i), 64'(blk), 64'(tbl[i].exp_blk));
            check($sformatf("tbl%0d_stall_cycles", i), 64'(sc), 64'(tbl[i].exp_sc));
        end

        // Six back-to-back dependencies on the same s0: 18 held cycles.
        for (int i = 0; i < 18; i++) step_tag(1'b0, 1'b1, 9, 1'b1, 1'b0);
        check("sat_counter_saturated", 64'(sc2), 64'd15);
        check("wide_counter_total", 64'(sc), 64'd22);

        // Flush in the second cycle of a stall.
        step_tag(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step_tag(1'b0, 1'b1, 21, 1'b0, 1'b0);
        step_tag(1'b0, 1'b1, 22, 1'b0, 1'b0);
        step_tag(1'b0, 1'b1, 23, 1'b1, 1'b0);
        step_tag(1'b0, 1'b1, 24, 1'b0, 1'b1);
        check("flush_s0_invalid", 64'(vs[0]), 64'd0);
        check("flush_s1_invalid", 64'(vs[1]), 64'd0);
        check("flush_s2_former_s1", 64'(vs[2]), 64'd0);
        check("flush_s3_producer", 64'(mc[3]), 64'(MICROCODE_W'(32'h100 + 21)));
        check("flush_unblocked", 64'(blk), 64'd0);
        check("flush_stall_cycles", 64'(sc), 64'd1);

        // Reset in the middle of a stall.
        step_tag(1'b0, 1'b1, 31, 1'b0, 1'b0);
        step_tag(1'b0, 1'b1, 32, 1'b1, 1'b0);
        step_tag(1'b0, 1'b1, 33, 1'b0, 1'b0);
        check("pre_rst_blocked", 64'(blk), 64'd1);
        step_tag(1'b1, 1'b1, 34, 1'b0, 1'b0);
        check("rst_valids", 64'({vs[3], vs[2], vs[1], vs[0]}), 64'd0);
        check("rst_microcode_s0", 64'(mc[0]), 64'd0);
        check("rst_blocked", 64'(blk), 64'd0);
        check("rst_stall_cycles", 64'(sc), 64'd0);
        check("rst_sat_stall_cycles", 64'(sc2), 64'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 70),
                 MICROCODE_W'($urandom),
                 INST_DATA_W'($urandom),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Owns the four pipeline stage registers (s0..s3): microcode, instruction data and a valid bit per stage.
- Sequences stage advance each cycle.
- Reacts to the data dependency detector's data_dependency flag by holding s0 and injecting bubbles into s1 until the producing instruction drains. It drives currently_blocked back to the detector.
- Also services branch flushes and keeps a stall-cycle performance counter.

Parameters:
- STALL_CYCLES, 3, total cycles s0 is held per detected dependency (detection cycle included); legal range 2..15.
- STALL_CNT_W, 16, width of the saturating stall performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch presents an instruction.
- fetch_microcode  in  22  microcode of fetched instruction.
- fetch_instruction_data  in  25  instruction data of fetched instruction.
- fetch_ready  out  1  s0 accepts fetch this cycle.
- data_dependency  in  1  from dependency detector (combinational on s0..s3 outputs).
- flush  in  1  branch redirect; discard s0 and s1.
- microcode_s0..microcode_s3  out  22 each  stage microcode registers.
- instruction_data_s0..instruction_data_s3  out  25 each  stage instruction-data registers.
- valid_s0..valid_s3  out  1 each  stage holds a real instruction.
- currently_blocked  out  1  registered; high in STALL state.
- stall_cycles  out  STALL_CNT_W  saturating count of held cycles.

Behaviour:
- Reset (clk edge with rst=1):
  - all microcode and instruction data go to NOP_MICROCODE / NOP_INSTRUCTION_DATA (all zeros); all valid bits go to 0.
  - state becomes RUN; stall_cnt, currently_blocked and stall_cycles go to 0.
  - rst mid-stall aborts the stall immediately.
- dep = data_dependency & valid_s0. This is used only in state RUN; the detector already masks the flag during STALL.
- Advance (no hold): s3<=s2, s2<=s1, s1<=s0, s0<=fetch when fetch_valid, else NOP with valid 0.
- Hold: s3<=s2, s2<=s1, s1<=NOP with valid 0, s0 unchanged.
- fetch_ready = ~rst & ~flush & state==RUN & ~dep. This is combinational and depends on the data_dependency input.
- FSM states: RUN, STALL.
  - RUN, dep=0: advance.
  - RUN, dep=1: hold; stall_cnt<=STALL_CYCLES-1; next STALL; stall_cycles++.
  - STALL: hold; stall_cycles++. If stall_cnt==1, next RUN; otherwise stall_cnt--.
  - With STALL_CYCLES=3, a producer in s1 at detection has left s3 before s0 is re-evaluated in RUN.
- currently_blocked = (state==STALL), registered.
- Flush has highest priority over dep and STALL:
  - s0 and s1 become NOP with valid 0; s3<=s2, s2<=s1 (pre-flush contents).
  - state<=RUN, stall_cnt<=0; fetch not accepted that cycle.
  - stall_cycles is not incremented in a flush cycle.
- stall_cycles saturates at all-ones; no wrap.
- Bubbles carry all-zero microcode: no register write enable and no rs1/rs2 check. A bubble can therefore never create or trigger a dependency.
- No dependency check occurs when s0 is invalid; an empty s0 always advances.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - MICROCODE_W=22 and INST_DATA_W=25.
  - NOP_MICROCODE and NOP_INSTRUCTION_DATA (all zeros).
  - The stall_state_t enum {RUN, STALL}.
  - A stage_t packed struct {valid, microcode, instruction_data}.
- Sub-module pipeline_stage_reg: one stage register with load/hold/bubble select and synchronous reset. It is instantiated four times.
- The FSM and counters stay in the top.

Test Plan:
- Reset then stream 4 independent valid instructions (dep=0) → each appears one stage later per cycle; valid_s3 high on cycle 4; currently_blocked=0; stall_cycles=0.
- Instruction A in s1 writes x5, B in s0 reads x5, dep=1 for one cycle:
  - B is held 3 cycles; s1 receives bubbles with microcode 0; fetch_ready=0 for 3 cycles.
  - currently_blocked=1 in cycles 2–3.
  - B reaches s1 on cycle 4; stall_cycles=3.
- Dependency with s0 invalid (valid_s0=0, data_dependency=1) → no stall, state stays RUN, stall_cycles unchanged.
- flush asserted in the second STALL cycle:
  - next cycle s0 and s1 are invalid and state is RUN; currently_blocked=0.
  - s2 holds the former s1; stall_cycles counts only 1 held cycle (the detection cycle).
- flush and dep in the same RUN cycle → flush wins; no STALL entry; s0 and s1 cleared; stall_cycles unchanged.
- With STALL_CNT_W=4, force 6 consecutive dependencies → stall_cycles saturates at 15. Separately, rst asserted mid-STALL → all outputs return to their reset values on the next edge.
